// File: rtl/uart_comm_pkg.sv
// uart_comm_pkg
// Shared types and constants for the host-side UART command endpoint.
// No ports; imported by uart_rx and uart_comm.

package uart_comm_pkg;

    // Receive-side state machine encoding
    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // Transmit-side state machine encoding
    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    // Number of serial bytes that make up one command word
    localparam int CMD_BYTES  = 3;
    localparam int BYTE_CNT_W = 2;

    // Width of a down-counter that must hold values 0..n-1
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_rx.sv
// uart_rx
// 8N1 receiver: two-flop synchronizer on the raw line, falling-edge start
// detection, mid-bit sampling, LSB-first deserialization.
// Ports:
//   clk_i      system clock
//   rst_i      asynchronous active-high reset
//   rx_i       raw serial input, idle high, asynchronous to clk_i
//   rx_byte_o  last received byte (valid while rx_vld_o is high)
//   rx_vld_o   1-clk pulse: byte received with a good stop bit
//   rx_ferr_o  1-clk pulse: stop bit sampled low, byte discarded
//   rx_idle_o  receiver FSM is in IDLE
//
// state    | meaning
// ---------+------------------------------------------------------
// RX_IDLE  | line idle, waiting for a synchronized falling edge
// RX_START | timing to mid start bit to reject glitches
// RX_DATA  | sampling 8 data bits at mid-bit, LSB first
// RX_STOP  | sampling the stop bit at mid-bit

module uart_rx
    import uart_comm_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic [7:0] rx_byte_o,
    output logic       rx_vld_o,
    output logic       rx_ferr_o,
    output logic       rx_idle_o
);

    localparam int CNT_W = cnt_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic             rx_meta_q;
    logic             rx_sync_q;
    logic             rx_prev_q;

    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             vld_q, vld_d;
    logic             ferr_q, ferr_d;

    // Synchronizer plus one extra stage for edge detection; all idle high
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            vld_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            vld_q   <= vld_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        vld_d   = 1'b0;
        ferr_d  = 1'b0;

        case (state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    state_d = RX_START;
                    cnt_d   = HALF_LOAD;
                end
            end
            RX_START: begin
                if (cnt_q == '0) begin
                    // Line back high at mid start bit: treat as a glitch
                    if (!rx_sync_q) begin
                        state_d = RX_DATA;
                        cnt_d   = BIT_LOAD;
                        bit_d   = 3'd0;
                    end else begin
                        state_d = RX_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (cnt_q == '0) begin
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    cnt_d   = BIT_LOAD;
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RX_STOP: begin
                // Return to IDLE at mid stop so the next start edge is not missed
                if (cnt_q == '0) begin
                    state_d = RX_IDLE;
                    if (rx_sync_q) begin
                        vld_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = RX_IDLE;
            end
        endcase
    end

    assign rx_byte_o = shift_q;
    assign rx_vld_o  = vld_q;
    assign rx_ferr_o = ferr_q;
    assign rx_idle_o = (state_q == RX_IDLE);

endmodule

// File: rtl/uart_comm.sv
// uart_comm
// Host-side serial endpoint: assembles three received bytes (MSB first) into
// a 24-bit command with a ready/clear handshake, and transmits single
// response bytes on request.
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   RX           serial from host, idle high, asynchronous
//   TX           serial to host, idle high
//   cmd          last complete command {byte0, byte1, byte2}
//   cmd_rdy      cmd holds a new, unconsumed command
//   clr_cmd_rdy  core acknowledges cmd
//   resp_data    response byte, sampled with send_resp
//   send_resp    1-clk request to transmit resp_data
//   resp_sent    1-clk pulse after the response stop bit completes
//   tx_busy      transmitter active
//   frame_err    1-clk pulse on a received byte with stop bit low
//
// state    | meaning
// ---------+------------------------------------------------------
// TX_IDLE  | line high, accepting send_resp
// TX_START | driving the start bit
// TX_DATA  | driving 8 data bits, LSB first
// TX_STOP  | driving the stop bit; resp_sent on its last clock edge

module uart_comm
    import uart_comm_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int TIMEOUT_CLKS = 20 * CLKS_PER_BIT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    output logic        TX,
    output logic [23:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp_data,
    input  logic        send_resp,
    output logic        resp_sent,
    output logic        tx_busy,
    output logic        frame_err
);

    localparam int CNT_W = cnt_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam int TO_W = cnt_width(TIMEOUT_CLKS);
    localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CLKS - 1);
    localparam logic [BYTE_CNT_W-1:0] LAST_IDX = BYTE_CNT_W'(CMD_BYTES - 1);

    logic [7:0] rx_byte;
    logic       rx_vld;
    logic       rx_ferr;
    logic       rx_idle;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk_i    (clk),
        .rst_i    (rst),
        .rx_i     (RX),
        .rx_byte_o(rx_byte),
        .rx_vld_o (rx_vld),
        .rx_ferr_o(rx_ferr),
        .rx_idle_o(rx_idle)
    );

    // ------------------------------------------------------------------
    // Command assembly
    // ------------------------------------------------------------------
    logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [15:0]           asm_q, asm_d;
    logic [23:0]           cmd_q, cmd_d;
    logic                  cmd_rdy_q, cmd_rdy_d;
    logic [TO_W-1:0]       to_cnt_q, to_cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt_q <= '0;
            asm_q      <= '0;
            cmd_q      <= '0;
            cmd_rdy_q  <= 1'b0;
            to_cnt_q   <= TO_LOAD;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
            cmd_q      <= cmd_d;
            cmd_rdy_q  <= cmd_rdy_d;
            to_cnt_q   <= to_cnt_d;
        end
    end

    always_comb begin
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        cmd_d      = cmd_q;
        cmd_rdy_d  = cmd_rdy_q;
        to_cnt_d   = TO_LOAD;

        if (clr_cmd_rdy) begin
            cmd_rdy_d = 1'b0;
        end

        if (rx_ferr) begin
            byte_cnt_d = '0;
        end else if (rx_vld) begin
            if (byte_cnt_q == LAST_IDX) begin
                // Completion overrides a coincident clr_cmd_rdy
                cmd_d      = {asm_q, rx_byte};
                cmd_rdy_d  = 1'b1;
                byte_cnt_d = '0;
            end else if (byte_cnt_q == '0) begin
                // A fresh command supersedes any unconsumed one
                asm_d[15:8] = rx_byte;
                cmd_rdy_d   = 1'b0;
                byte_cnt_d  = byte_cnt_q + BYTE_CNT_W'(1);
            end else begin
                asm_d[7:0] = rx_byte;
                byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(1);
            end
        end else if ((byte_cnt_q != '0) && rx_idle) begin
            // Counts consecutive idle clocks with a partial command pending
            if (to_cnt_q == '0) begin
                byte_cnt_d = '0;
            end else begin
                to_cnt_d = to_cnt_q - TO_W'(1);
            end
        end
    end

    assign cmd       = cmd_q;
    assign cmd_rdy   = cmd_rdy_q;
    assign frame_err = rx_ferr;

    // ------------------------------------------------------------------
    // Response transmitter
    // ------------------------------------------------------------------
    tx_state_t        tx_state_q, tx_state_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]       tx_bit_q, tx_bit_d;
    logic [7:0]       tx_shift_q, tx_shift_d;
    logic             tx_q, tx_d;
    logic             resp_sent_q, resp_sent_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q  <= TX_IDLE;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_shift_q  <= '0;
            tx_q        <= 1'b1;
            resp_sent_q <= 1'b0;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_shift_q  <= tx_shift_d;
            tx_q        <= tx_d;
            resp_sent_q <= resp_sent_d;
        end
    end

    // TX is a register: the line level for the next bit is chosen here so
    // that it changes on exactly the edge the bit period ends.
    always_comb begin
        tx_state_d  = tx_state_q;
        tx_cnt_d    = tx_cnt_q;
        tx_bit_d    = tx_bit_q;
        tx_shift_d  = tx_shift_q;
        tx_d        = tx_q;
        resp_sent_d = 1'b0;

        case (tx_state_q)
            TX_IDLE: begin
                tx_d = 1'b1;
                if (send_resp) begin
                    tx_state_d = TX_START;
                    tx_shift_d = resp_data;
                    tx_cnt_d   = BIT_LOAD;
                    tx_d       = 1'b0;
                end
            end
            TX_START: begin
                if (tx_cnt_q == '0) begin
                    tx_state_d = TX_DATA;
                    tx_cnt_d   = BIT_LOAD;
                    tx_bit_d   = 3'd0;
                    tx_d       = tx_shift_q[0];
                end else begin
                    tx_cnt_d = tx_cnt_q - CNT_W'(1);
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == '0) begin
                    tx_cnt_d = BIT_LOAD;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = TX_STOP;
                        tx_d       = 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_d       = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - CNT_W'(1);
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == '0) begin
                    tx_state_d  = TX_IDLE;
                    resp_sent_d = 1'b1;
                    tx_d        = 1'b1;
                end else begin
                    tx_cnt_d = tx_cnt_q - CNT_W'(1);
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
                tx_d       = 1'b1;
            end
        endcase
    end

    assign TX        = tx_q;
    assign tx_busy   = (tx_state_q != TX_IDLE);
    assign resp_sent = resp_sent_q;

endmodule

// File: tb/tb_uart_comm.sv
module tb_uart_comm;

    localparam int CPB     = 16;
    localparam int TIMEOUT = 20 * CPB;
    localparam int RESP_LAT = 10 * CPB + 1;

    logic        clk;
    logic        rst;
    logic        RX;
    logic        TX;
    logic [23:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic [7:0]  resp_data;
    logic        send_resp;
    logic        resp_sent;
    logic        tx_busy;
    logic        frame_err;

    uart_comm #(
        .CLKS_PER_BIT(CPB),
        .TIMEOUT_CLKS(TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .RX         (RX),
        .TX         (TX),
        .cmd        (cmd),
        .cmd_rdy    (cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy),
        .resp_data  (resp_data),
        .send_resp  (send_resp),
        .resp_sent  (resp_sent),
        .tx_busy    (tx_busy),
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ferr_cnt = 0;

    logic [23:0] cmd_exp[$];
    logic [7:0]  tx_exp[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic fail(input string nm, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s actual=%0h required=none", nm, act);
    endtask

    // ---------------- monitors ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (frame_err === 1'b1) ferr_cnt++;
        end
    end

    // Command scoreboard: pop on every rising edge of cmd_rdy
    initial begin
        logic rdy_prev;
        rdy_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && cmd_rdy === 1'b1 && !rdy_prev) begin
                if (cmd_exp.size() == 0) fail("cmd_unexpected", {8'h0, cmd});
                else chk("cmd_value", {8'h0, cmd}, {8'h0, cmd_exp.pop_front()});
            end
            rdy_prev = (cmd_rdy === 1'b1);
        end
    end

    // TX line decoder: mid-bit sampling; frames cut by reset are dropped
    initial begin
        logic [7:0] b;
        logic       stop_v;
        logic       ab;
        forever begin
            @(negedge clk);
            if (!rst && TX === 1'b0) begin
                ab = 1'b0;
                b  = 8'h00;
                for (int j = 0; j < CPB / 2; j++) begin
                    @(negedge clk);
                    if (rst) ab = 1'b1;
                end
                for (int k = 0; k < 8; k++) begin
                    for (int j = 0; j < CPB; j++) begin
                        @(negedge clk);
                        if (rst) ab = 1'b1;
                    end
                    b[k] = TX;
                end
                for (int j = 0; j < CPB; j++) begin
                    @(negedge clk);
                    if (rst) ab = 1'b1;
                end
                stop_v = TX;
                if (!ab) begin
                    if (tx_exp.size() == 0) fail("tx_unexpected", {24'h0, b});
                    else chk("tx_byte", {24'h0, b}, {24'h0, tx_exp.pop_front()});
                    chk("tx_stop_bit", {31'h0, stop_v}, 32'h1);
                end
            end
        end
    end

    initial begin
        #(80000 * 10);
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1, input int gap = CPB);
        RX = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (CPB) @(negedge clk);
        end
        RX = stop_bit;
        repeat (CPB) @(negedge clk);
        RX = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_cmd(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [23:0] exp_cmd);
        cmd_exp.push_back(exp_cmd);
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
    endtask

    task automatic resp_start(input logic [7:0] b, output int c0);
        c0 = cyc;
        send_resp = 1'b1;
        resp_data = b;
        tx_exp.push_back(b);
        @(negedge clk);
        send_resp = 1'b0;
        resp_data = 8'h00;
    endtask

    task automatic wait_resp(input int c0, output int lat);
        while (resp_sent !== 1'b1 && (cyc - c0) < 400) @(negedge clk);
        lat = cyc - c0;
    endtask

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic [23:0] exp_cmd;
    } cmd_vec_t;

    typedef struct {
        logic [7:0] data;
        int         exp_lat;
    } resp_vec_t;

    cmd_vec_t  cmd_tbl[4];
    resp_vec_t resp_tbl[4];

    initial begin
        int c0;
        int lat;
        int f0;
        int n;

        cmd_tbl[0] = '{8'h12, 8'h34, 8'h56, 24'h123456};
        cmd_tbl[1] = '{8'h00, 8'h00, 8'h00, 24'h000000};
        cmd_tbl[2] = '{8'hFF, 8'hFF, 8'hFF, 24'hFFFFFF};
        cmd_tbl[3] = '{8'hA5, 8'h5A, 8'hC3, 24'hA55AC3};
        resp_tbl[0] = '{8'hA5, RESP_LAT};
        resp_tbl[1] = '{8'h00, RESP_LAT};
        resp_tbl[2] = '{8'hFF, RESP_LAT};
        resp_tbl[3] = '{8'h3C, RESP_LAT};

        rst = 1'b1;
        RX = 1'b1;
        clr_cmd_rdy = 1'b0;
        send_resp = 1'b0;
        resp_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_TX", {31'h0, TX}, 32'h1);
        chk("rst_cmd", {8'h0, cmd}, 32'h0);
        chk("rst_cmd_rdy", {31'h0, cmd_rdy}, 32'h0);
        chk("rst_resp_sent", {31'h0, resp_sent}, 32'h0);
        chk("rst_tx_busy", {31'h0, tx_busy}, 32'h0);
        chk("rst_frame_err", {31'h0, frame_err}, 32'h0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // 1: command table with handshake
        for (int i = 0; i < 4; i++) begin
            send_cmd(cmd_tbl[i].b0, cmd_tbl[i].b1, cmd_tbl[i].b2, cmd_tbl[i].exp_cmd);
            chk("cmd_rdy_set", {31'h0, cmd_rdy}, 32'h1);
            clr_cmd_rdy = 1'b1;
            @(negedge clk);
            clr_cmd_rdy = 1'b0;
            chk("cmd_rdy_cleared", {31'h0, cmd_rdy}, 32'h0);
            chk("cmd_held", {8'h0, cmd}, {8'h0, cmd_tbl[i].exp_cmd});
        end
        chk("cmd_queue_t1", cmd_exp.size(), 0);

        // 2: response with ignored mid-frame request
        resp_start(8'hA5, c0);
        chk("tx_start_low", {31'h0, TX}, 32'h0);
        chk("tx_busy_start", {31'h0, tx_busy}, 32'h1);
        repeat (48) @(negedge clk);
        send_resp = 1'b1;
        resp_data = 8'h3C;
        @(negedge clk);
        send_resp = 1'b0;
        resp_data = 8'h00;
        wait_resp(c0, lat);
        chk("resp_latency_a5", lat, RESP_LAT);
        chk("tx_busy_at_sent", {31'h0, tx_busy}, 32'h0);
        @(negedge clk);
        chk("resp_sent_width", {31'h0, resp_sent}, 32'h0);
        repeat (200) @(negedge clk);
        chk("no_queued_tx", {31'h0, tx_busy}, 32'h0);

        // response table
        for (int i = 0; i < 4; i++) begin
            resp_start(resp_tbl[i].data, c0);
            wait_resp(c0, lat);
            chk("resp_latency", lat, resp_tbl[i].exp_lat);
            @(negedge clk);
            repeat (10) @(negedge clk);
        end

        // back-to-back request issued in the resp_sent cycle
        resp_start(8'h5A, c0);
        wait_resp(c0, lat);
        chk("resp_latency_b2b_first", lat, RESP_LAT);
        resp_start(8'hC3, c0);
        chk("b2b_accepted_busy", {31'h0, tx_busy}, 32'h1);
        wait_resp(c0, lat);
        chk("resp_latency_b2b_second", lat, RESP_LAT);
        repeat (20) @(negedge clk);
        chk("tx_queue_t2", tx_exp.size(), 0);

        // 3: timeout discards partial command; shorter idle keeps it
        send_byte(8'h01);
        send_byte(8'h02, 1'b1, TIMEOUT + 80);
        send_cmd(8'hAA, 8'hBB, 8'hCC, 24'hAABBCC);
        chk("cmd_after_timeout", {8'h0, cmd}, 32'hAABBCC);
        cmd_exp.push_back(24'h445566);
        send_byte(8'h44, 1'b1, TIMEOUT - 70);
        send_byte(8'h55);
        send_byte(8'h66);
        chk("cmd_below_timeout", {8'h0, cmd}, 32'h445566);
        chk("cmd_queue_t3", cmd_exp.size(), 0);

        // 4: framing error resets byte count
        send_byte(8'h77);
        f0 = ferr_cnt;
        send_byte(8'h12, 1'b0, 2 * CPB);
        chk("frame_err_pulses", ferr_cnt - f0, 1);
        send_cmd(8'h11, 8'h22, 8'h33, 24'h112233);
        chk("cmd_queue_t4", cmd_exp.size(), 0);

        // 5: glitch rejection, superseding, coincident clr
        f0 = ferr_cnt;
        send_byte(8'h01);
        chk("new_cmd_supersedes", {31'h0, cmd_rdy}, 32'h0);
        RX = 1'b0;
        repeat (4) @(negedge clk);
        RX = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        chk("glitch_no_ferr", ferr_cnt - f0, 0);
        send_byte(8'h02);
        cmd_exp.push_back(24'h010203);
        fork
            send_byte(8'h03);
            begin
                n = 0;
                while (dut.rx_vld !== 1'b1 && n < 300) begin
                    @(negedge clk);
                    n++;
                end
                if (n >= 300) fail("rx_vld_wait_expired", n);
                clr_cmd_rdy = 1'b1;
                @(negedge clk);
                clr_cmd_rdy = 1'b0;
                chk("coincident_clr_set_wins", {31'h0, cmd_rdy}, 32'h1);
            end
        join
        chk("cmd_after_glitch", {8'h0, cmd}, 32'h010203);
        chk("cmd_queue_t5", cmd_exp.size(), 0);

        // 6: reset mid-TX data bit and mid-RX second byte
        send_byte(8'h12);
        fork
            send_byte(8'h34);
            begin
                repeat (40) @(negedge clk);
                resp_start(8'h5A, c0);
                repeat (40) @(negedge clk);
                rst = 1'b1;
                #1;
                chk("async_rst_TX", {31'h0, TX}, 32'h1);
                chk("async_rst_tx_busy", {31'h0, tx_busy}, 32'h0);
                chk("async_rst_cmd_rdy", {31'h0, cmd_rdy}, 32'h0);
                chk("async_rst_cmd", {8'h0, cmd}, 32'h0);
            end
        join
        tx_exp.delete();
        cmd_exp.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        send_cmd(8'hC0, 8'hFF, 8'hEE, 24'hC0FFEE);
        chk("cmd_after_reset", {8'h0, cmd}, 32'hC0FFEE);
        resp_start(8'h81, c0);
        wait_resp(c0, lat);
        chk("resp_latency_after_reset", lat, RESP_LAT);
        repeat (20) @(negedge clk);
        chk("cmd_queue_final", cmd_exp.size(), 0);
        chk("tx_queue_final", tx_exp.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
